// File: rtl/fpalu_add_align.sv
// Pre-add stage of the binary32 adder: unpack, classify specials, order by magnitude,
// then right-align the smaller mantissa with guard/round/sticky. Two valid/ready stages.
module fpalu_add_align #(
    parameter int MW = 27,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   a,
    input  logic [31:0]   b,
    input  logic          op_sub,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          big_sign,
    output logic [EW-1:0] big_exp,
    output logic [MW-1:0] big_man,
    output logic [MW-1:0] small_man,
    output logic          eff_sub,
    output logic          out_special,
    output logic [31:0]   spec_word
);

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [MW-1:0] bman;
        logic [MW-1:0] sman;
        logic [EW-1:0] diff;
        logic          effsub;
        logic          special;
        logic [31:0]   spec;
    } s1_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic [EW-1:0] eff_exp(input logic [EW-1:0] e);
        return (e == '0) ? EW'(1) : e;
    endfunction

    logic [2:1]    vld_pipe;
    logic          s1_adv, s2_adv;
    s1_t           s1_d, s1_q;
    logic [MW-1:0] sman_d;

    assign s2_adv    = out_ready | ~vld_pipe[2];
    assign s1_adv    = s2_adv | ~vld_pipe[1];
    assign in_ready  = s1_adv;
    assign out_valid = vld_pipe[2];

    // Stage 1: unpack, magnitude compare/swap, special classification
    logic          sa, sb, swap, nan_a, nan_b, inf_a, inf_b;
    logic [EW-1:0] ea, eb, e_big, e_sml;
    logic [22:0]   fa, fb, f_big, f_sml;

    always_comb begin
        sa    = a[31];
        sb    = b[31] ^ op_sub;
        ea    = a[30:23];
        eb    = b[30:23];
        fa    = a[22:0];
        fb    = b[22:0];
        swap  = {eb, fb} > {ea, fa};
        e_big = swap ? eb : ea;
        f_big = swap ? fb : fa;
        e_sml = swap ? ea : eb;
        f_sml = swap ? fa : fb;
        nan_a = (ea == '1) && (fa != '0);
        nan_b = (eb == '1) && (fb != '0);
        inf_a = (ea == '1) && (fa == '0);
        inf_b = (eb == '1) && (fb == '0);

        s1_d         = '0;
        s1_d.sign    = swap ? sb : sa;
        s1_d.exp     = eff_exp(e_big);
        s1_d.bman    = {e_big != '0, f_big, 3'b000};
        s1_d.sman    = {e_sml != '0, f_sml, 3'b000};
        s1_d.diff    = eff_exp(e_big) - eff_exp(e_sml);
        s1_d.effsub  = sa ^ sb;
        s1_d.special = nan_a | nan_b | inf_a | inf_b;
        if (nan_a || nan_b || (inf_a && inf_b && s1_d.effsub))
            s1_d.spec = QNAN;
        else if (inf_a || inf_b)
            s1_d.spec = {inf_a ? sa : sb, 8'hFF, 23'h0};
    end

    // Stage 2: alignment shift; everything shifted out folds into bit 0
    logic [MW-1:0] mask;
    always_comb begin
        sman_d = '0;
        mask   = '0;
        if (s1_q.diff >= EW'(MW)) begin
            sman_d[0] = |s1_q.sman;
        end else begin
            mask      = ~({MW{1'b1}} << s1_q.diff);
            sman_d    = s1_q.sman >> s1_q.diff;
            sman_d[0] = sman_d[0] | (|(s1_q.sman & mask));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe    <= '0;
            s1_q        <= '0;
            big_sign    <= 1'b0;
            big_exp     <= '0;
            big_man     <= '0;
            small_man   <= '0;
            eff_sub     <= 1'b0;
            out_special <= 1'b0;
            spec_word   <= '0;
        end else begin
            if (s1_adv) vld_pipe[1] <= in_valid;
            if (s1_adv && in_valid) s1_q <= s1_d;
            if (s2_adv) vld_pipe[2] <= vld_pipe[1];
            if (s2_adv && vld_pipe[1]) begin
                big_sign    <= s1_q.sign;
                big_exp     <= s1_q.exp;
                big_man     <= s1_q.bman;
                small_man   <= sman_d;
                eff_sub     <= s1_q.effsub;
                out_special <= s1_q.special;
                spec_word   <= s1_q.spec;
            end
        end
    end

endmodule
